// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard unit for a five-stage pipeline with a multi-cycle multiply/divide unit.
// Resolves data hazards by forwarding into EX and into the decode-stage branch
// comparator. It stalls the front end on load-use hazards, on branch operand
// hazards and on multiply/divide ops that issue while the MDU is busy.
//
// Ports:
//   clk, rst                        clock and asynchronous active-high reset
//   RsD, RtD                        decode-stage source registers
//   RsE, RtE                        execute-stage source registers
//   WriteRegE/M/W, RegWriteE/M/W    destination register and write enable per stage
//   MemtoRegE, MemtoRegM            load in EX / load in MEM
//   BranchD                         branch in decode
//   MdOpD                           mult/div/mfhi/mflo in decode
//   MdStartE                        mult/div issuing in EX
//   ForwardAE, ForwardBE            EX operand select: 00 regfile, 01 MEM, 10 WB
//   ForwardAD, ForwardBD            forward the MEM result into the decode comparator
//   StallF, StallD, FlushE          hold PC and IF/ID, clear ID/EX
//   MdBusy                          multiply/divide unit busy
//   StallCount                      saturating count of stall cycles
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MDU_CYCLES = 32,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MdOpD,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic [PERF_W-1:0] StallCount
);

  // An 8-bit down-counter covers the whole legal MDU_CYCLES range.
  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

  mdState_t         state;
  mdState_t         nextState;
  logic [CNT_W-1:0] mdCount;
  logic [CNT_W-1:0] nextCount;

  logic lwStall;
  logic brStall;
  logic mdStall;
  logic stallAny;

  // Register 0 is hardwired to zero, so a match on address 0 never means a
  // real dependency.
  function automatic logic regMatch(input logic [REG_AW-1:0] a,
                                    input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // EX-stage forwarding; the MEM result is younger, so it takes priority
  // over WB.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && regMatch(RsE, WriteRegM))
      ForwardAE = 2'b01;
    else if (RegWriteW && regMatch(RsE, WriteRegW))
      ForwardAE = 2'b10;
    if (RegWriteM && regMatch(RtE, WriteRegM))
      ForwardBE = 2'b01;
    else if (RegWriteW && regMatch(RtE, WriteRegW))
      ForwardBE = 2'b10;
  end

  // Decode-stage branch comparator forwarding and the three stall sources.
  // A branch must wait for an ALU result still in EX, or for a load still in
  // MEM, because neither value exists yet when the comparator needs it.
  always_comb begin
    ForwardAD = RegWriteM && regMatch(RsD, WriteRegM);
    ForwardBD = RegWriteM && regMatch(RtD, WriteRegM);
    lwStall   = MemtoRegE && (regMatch(RtE, RsD) || regMatch(RtE, RtD));
    brStall   = BranchD &&
                ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                 (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));
    mdStall   = MdOpD && MdBusy;
    stallAny  = lwStall || brStall || mdStall;
    StallF    = stallAny;
    StallD    = stallAny;
    FlushE    = stallAny;
  end

  // MDU busy tracker state register; reset clears it asynchronously, so
  // MdBusy and any MDU stall drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mdCount <= '0;
    end else begin
      state   <= nextState;
      mdCount <= nextCount;
    end
  end

  // Loading MDU_CYCLES-1 and leaving on the edge that sees zero keeps MdBusy
  // high for exactly MDU_CYCLES cycles. A start request seen in BUSY,
  // including on the final edge, is dropped.
  always_comb begin
    nextState = state;
    nextCount = mdCount;
    case (state)
      IDLE: begin
        if (MdStartE) begin
          nextState = BUSY;
          nextCount = CNT_LOAD;
        end
      end
      BUSY: begin
        if (mdCount == '0) begin
          nextState = IDLE;
        end else begin
          nextCount = mdCount - 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
        nextCount = '0;
      end
    endcase
  end

  assign MdBusy = (state == BUSY);

  // Stall-cycle performance counter; it saturates rather than wraps so a long
  // run never reports a misleadingly small number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != '1)) begin
      StallCount <= StallCount + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl with MDU_CYCLES=4 and PERF_W=4. A table
// of combinational vectors covers forwarding and stall decisions. Hand-written
// sequences cover the stall counter, its saturation, the MDU busy window and
// asynchronous reset.
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int MDU_CYC = 4;
  localparam int PERF_W = 4;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic              BranchD, MdOpD, MdStartE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;
  logic [PERF_W-1:0] StallCount;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .REG_AW    (REG_AW),
    .MDU_CYCLES(MDU_CYC),
    .PERF_W    (PERF_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .MdOpD     (MdOpD),
    .MdStartE  (MdStartE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE),
    .MdBusy    (MdBusy),
    .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string      name;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       regWE, regWM, regWW, memE, memM, branchD, mdOpD;
    logic [1:0] fAE, fBE;
    logic       fAD, fBD, stall;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name,
                        input logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW,
                        input logic regWE, regWM, regWW, memE, memM, branchD, mdOpD,
                        input logic [1:0] fAE, fBE,
                        input logic fAD, fBD, stall);
    vec_t v;
    v.name = name; v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.wrE = wrE; v.wrM = wrM; v.wrW = wrW;
    v.regWE = regWE; v.regWM = regWM; v.regWW = regWW;
    v.memE = memE; v.memM = memM; v.branchD = branchD; v.mdOpD = mdOpD;
    v.fAE = fAE; v.fBE = fBE; v.fAD = fAD; v.fBD = fBD; v.stall = stall;
    vecs.push_back(v);
  endtask

  task automatic clearInputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
    MdOpD = 1'b0; MdStartE = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    RsD = v.rsD; RtD = v.rtD; RsE = v.rsE; RtE = v.rtE;
    WriteRegE = v.wrE; WriteRegM = v.wrM; WriteRegW = v.wrW;
    RegWriteE = v.regWE; RegWriteM = v.regWM; RegWriteW = v.regWW;
    MemtoRegE = v.memE; MemtoRegM = v.memM; BranchD = v.branchD;
    MdOpD = v.mdOpD; MdStartE = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();

    //       name        rsD rtD rsE rtE wrE wrM wrW rWE rWM rWW mE mM br md  fAE    fBE    fAD fBD st
    addVec("fwdMem",      0,  0,  3,  3,  0,  3,  3,  0,  1,  1, 0, 0, 0, 0, 2'b01, 2'b01, 0,  0,  0);
    addVec("fwdWb",       0,  0,  3,  3,  0,  3,  3,  0,  0,  1, 0, 0, 0, 0, 2'b10, 2'b10, 0,  0,  0);
    addVec("fwdZero",     0,  0,  0,  0,  0,  0,  0,  1,  1,  1, 0, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0);
    addVec("fwdMix",      0,  0,  4,  6,  0,  4,  6,  0,  1,  1, 0, 0, 0, 0, 2'b01, 2'b10, 0,  0,  0);
    addVec("fwdNoWe",     0,  0,  4,  6,  0,  4,  6,  0,  0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0);
    addVec("lwRs",        5,  0,  0,  5,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 2'b00, 2'b00, 0,  0,  1);
    addVec("lwRt",        0,  5,  0,  5,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 2'b00, 2'b00, 0,  0,  1);
    addVec("lwZero",      0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0);
    addVec("lwNoMatch",   6,  7,  0,  5,  0,  0,  0,  0,  0,  0, 1, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0);
    addVec("brAlu",       0,  7,  0,  0,  7,  0,  0,  1,  0,  0, 0, 0, 1, 0, 2'b00, 2'b00, 0,  0,  1);
    addVec("brLoad",      0,  7,  0,  0,  0,  7,  0,  0,  1,  0, 0, 1, 1, 0, 2'b00, 2'b00, 0,  1,  1);
    addVec("brFwd",       0,  7,  0,  0,  0,  7,  0,  0,  1,  0, 0, 0, 1, 0, 2'b00, 2'b00, 0,  1,  0);
    addVec("fwdAD",       9,  0,  0,  0,  0,  9,  0,  0,  1,  0, 0, 0, 0, 0, 2'b00, 2'b00, 1,  0,  0);
    addVec("brZero",      0,  0,  0,  0,  0,  0,  0,  1,  1,  0, 0, 1, 1, 0, 2'b00, 2'b00, 0,  0,  0);
    addVec("brNoBranch",  0,  7,  0,  0,  7,  0,  0,  1,  0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0,  0,  0);
    addVec("mdIdle",      0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 2'b00, 2'b00, 0,  0,  0);

    // Asynchronous reset state, before any clock edge.
    #2;
    checkOutput("rstBusy", 16'(MdBusy), 16'd0);
    checkOutput("rstCount", 16'(StallCount), 16'd0);
    checkOutput("rstStall", 16'(StallF), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, ".ForwardAE"}, 16'(ForwardAE), 16'(vecs[i].fAE));
      checkOutput({vecs[i].name, ".ForwardBE"}, 16'(ForwardBE), 16'(vecs[i].fBE));
      checkOutput({vecs[i].name, ".ForwardAD"}, 16'(ForwardAD), 16'(vecs[i].fAD));
      checkOutput({vecs[i].name, ".ForwardBD"}, 16'(ForwardBD), 16'(vecs[i].fBD));
      checkOutput({vecs[i].name, ".StallF"}, 16'(StallF), 16'(vecs[i].stall));
      checkOutput({vecs[i].name, ".StallD"}, 16'(StallD), 16'(vecs[i].stall));
      checkOutput({vecs[i].name, ".FlushE"}, 16'(FlushE), 16'(vecs[i].stall));
    end

    // Stall counter counts one per stalled edge and holds when stalls stop.
    clearInputs();
    doReset();
    checkOutput("cntAfterRst", 16'(StallCount), 16'd0);
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("cntStep", 16'(StallCount), 16'(i + 1));
    end
    clearInputs();
    @(negedge clk);
    #1;
    checkOutput("cntHold", 16'(StallCount), 16'd3);

    // Saturation at all-ones after 20 continuous stall cycles.
    doReset();
    MemtoRegE = 1'b1; RtE = 5'd5; RtD = 5'd5;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("cnt10", 16'(StallCount), 16'd10);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("cntSat", 16'(StallCount), 16'd15);
    clearInputs();

    // MDU window: busy exactly MDU_CYC cycles, MdOpD stalls throughout.
    doReset();
    @(negedge clk);
    MdStartE = 1'b1;
    MdOpD = 1'b1;
    #1;
    checkOutput("mdPreBusy", 16'(MdBusy), 16'd0);
    checkOutput("mdPreStall", 16'(StallF), 16'd0);
    @(posedge clk);
    #1;
    MdStartE = 1'b0;
    for (int i = 0; i < MDU_CYC + 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("mdWinBusy", 16'(MdBusy), 16'(i < MDU_CYC));
      checkOutput("mdWinStall", 16'(StallF), 16'(i < MDU_CYC));
    end
    MdOpD = 1'b0;

    // Start requests inside BUSY and on the final edge are ignored.
    @(negedge clk);
    MdStartE = 1'b1;
    @(posedge clk);
    #1;
    MdStartE = 1'b0;
    for (int i = 0; i < MDU_CYC + 1; i++) begin
      @(negedge clk);
      #1;
      checkOutput("mdIgnBusy", 16'(MdBusy), 16'(i < MDU_CYC));
      if (i == 1 || i == MDU_CYC - 1) MdStartE = 1'b1;
      else MdStartE = 1'b0;
    end
    MdStartE = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mdIgnIdle", 16'(MdBusy), 16'd0);

    // Asynchronous reset in the middle of BUSY, then a full restart.
    MdStartE = 1'b1;
    MdOpD = 1'b1;
    @(posedge clk);
    #1;
    MdStartE = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstMidBusyPre", 16'(MdBusy), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMidBusy", 16'(MdBusy), 16'd0);
    checkOutput("rstMidStall", 16'(StallF), 16'd0);
    checkOutput("rstMidCount", 16'(StallCount), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    MdStartE = 1'b1;
    @(posedge clk);
    #1;
    MdStartE = 1'b0;
    for (int i = 0; i < MDU_CYC + 1; i++) begin
      @(negedge clk);
      #1;
      checkOutput("mdRestart", 16'(MdBusy), 16'(i < MDU_CYC));
    end
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
